pcie_scrambler_par: RTL and testbench
=====================================

Name: pcie_scrambler_par

Overview:
- Multi-byte PCIe Gen1/Gen2 8b/10b scrambler.
- Polynomial x^16+x^5+x^4+x^3+1, Galois form, seed 16'hFFFF.
- Scrambles NUM_BYTES symbols per clock, lowest byte first, and handles COM/SKP K-symbol rules internally.
- Sits between the TX data path (framing/ordered-set mux) and the 8b/10b encoder, one instance per lane.

Parameters:
- NUM_BYTES, 1, symbols per beat; legal values 1, 2, 4; byte 0 (bits [7:0]) is first in time.
- SEED, 16'hFFFF, LFSR value loaded on reset, on COM and on scrambler_reset.

Ports:
- clk_i  in  1  clock.
- system_reset  in  1  asynchronous, active-low reset.
- scrambler_reset  in  1  synchronous LFSR reload to SEED.
- scrambler_disable  in  1  when 1, data symbols pass unscrambled; LFSR still advances.
- in_valid  in  1  beat valid.
- in_data  in  8*NUM_BYTES  symbols.
- in_k  in  NUM_BYTES  per-byte K flag.
- out_valid  out  1  registered beat valid.
- out_data  out  8*NUM_BYTES  scrambled symbols.
- out_k  out  NUM_BYTES  in_k delayed to align with out_data.

Behaviour:
- Reset (system_reset=0): lfsr=SEED, out_valid=0, out_data=0, out_k=0.
- Latency: exactly 1 cycle, in_valid -> out_valid. No backpressure; the block is always ready.
- in_valid=0: LFSR holds. out_valid=0 next cycle. out_data/out_k hold their last values.
- Per-byte processing, applied to byte 0, 1, ... in sequence within a single combinational cycle. Each byte sees the LFSR state left by the previous byte.
  - K and byte==8'hBC (COM): output unchanged, and the LFSR is set to SEED with no advance. The next byte uses SEED.
  - K and byte==8'h1C (SKP): output unchanged, LFSR not advanced.
  - Other K: output unchanged, LFSR advanced 8 steps.
  - D: LFSR advanced 8 steps. Output = data XOR scramble byte, unless scrambler_disable=1.
- Scramble byte generation: for step i=0..7, bit i = lfsr[15]; then one Galois shift: new[0]=lfsr[15]; new[3], new[4], new[5] = lfsr[n-1]^lfsr[15]; other bits shift up.
- Zero-data scramble sequence from SEED: FF, 17, C0, 14, B2, E7, 02, 82.
- scrambler_reset=1 with in_valid=1: the reload takes effect before the beat is processed, so byte 0 uses SEED.
- scrambler_reset=1 with in_valid=0: LFSR=SEED next cycle.
- A COM in the middle of a beat reseeds for the remaining bytes of the same beat.
- Several COM/SKP in one beat: the rules are applied in byte order, no special casing.
- system_reset asserted mid-stream: the in-flight beat is dropped (out_valid=0), and the first beat after release uses SEED.
- LFSR state update is registered only on beats with in_valid=1 or scrambler_reset=1.

Optional Feature:
- Macro: SCR_SEED_LOAD_EN.
- Defined: adds ports seed_load (in, 1) and seed_value (in, 16), plus lfsr_state_o (out, 16, registered current LFSR, reset SEED).
  - seed_load=1 loads seed_value into the LFSR with the same priority and timing as scrambler_reset.
  - If both are asserted, seed_load wins.
  - COM still reloads the SEED parameter, not seed_value.
- Undefined: these ports are absent and the LFSR is reachable only via reset, COM and scrambler_reset.

Test Plan:
- NUM_BYTES=1, beats BC(K), 00, 00, 00 -> out BC(K), FF, 17, C0, each 1 cycle after input.
- NUM_BYTES=1, beats BC(K), 1C(K), 1C(K), 00, 00 -> BC, 1C, 1C, FF, 17 (SKP does not advance LFSR).
- NUM_BYTES=4, in_data bytes [0..3]=BC,00,00,00, in_k=4'b0001, then 00,00,00,00 -> BC,FF,17,C0 then 14,B2,E7,02.
- NUM_BYTES=1, BC(K), 00 with scrambler_disable=1, then 00 with disable=0 -> BC, 00, 17 (LFSR advanced while disabled).
- NUM_BYTES=1, BC(K), 00, then in_valid=0 for 5 cycles, then 00 -> FF then 17; out_valid low during the gap.
- NUM_BYTES=1, after 3 data bytes pulse scrambler_reset with in_valid=1, data 00 -> out FF.
- NUM_BYTES=1, async system_reset pulse mid-stream -> out_valid=0, out_data=0 immediately; next 00 -> FF.

Source files
------------

// File: rtl/pcie_scrambler_par_if.sv
// Beat-level bus between the TX framing mux and the per-lane scrambler.
// Handshake: there is no ready; the sink always accepts, so a beat transfers on
// every clock where in_valid is 1, and out_valid marks each registered result beat.
interface pcie_scrambler_par_if #(
    parameter int NUM_BYTES = 1
);
    logic                   in_valid;
    logic [8*NUM_BYTES-1:0] in_data;
    logic [NUM_BYTES-1:0]   in_k;
    logic                   out_valid;
    logic [8*NUM_BYTES-1:0] out_data;
    logic [NUM_BYTES-1:0]   out_k;

    modport master (
        output in_valid, in_data, in_k,
        input  out_valid, out_data, out_k
    );

    modport slave (
        input  in_valid, in_data, in_k,
        output out_valid, out_data, out_k
    );
endinterface

// File: rtl/pcie_scrambler_par.sv
// Multi-byte PCIe Gen1/Gen2 scrambler (x^16+x^5+x^4+x^3+1, Galois), byte 0 first in time.
// Optional SCR_SEED_LOAD_EN adds seed_load/seed_value inputs and the lfsr_state_o observation port.
module pcie_scrambler_par #(
    parameter int          NUM_BYTES = 1,
    parameter logic [15:0] SEED      = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        system_reset,
    input  logic        scrambler_reset,
    input  logic        scrambler_disable,
`ifdef SCR_SEED_LOAD_EN
    input  logic        seed_load,
    input  logic [15:0] seed_value,
    output logic [15:0] lfsr_state_o,
`endif
    pcie_scrambler_par_if.slave bus
);

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;

    logic [15:0]            r_lfsr;
    logic                   r_out_valid;
    logic [8*NUM_BYTES-1:0] r_out_data;
    logic [NUM_BYTES-1:0]   r_out_k;

    logic [15:0]            w_lfsr_start;
    logic [15:0]            w_lfsr_next;
    logic                   w_reload;
    logic [8*NUM_BYTES-1:0] w_out_data;

    // Returns {scramble_byte, lfsr_after_8_steps}; bit i of the byte is lfsr[15] before step i.
    function automatic logic [23:0] scr_advance8(input logic [15:0] l_in);
        logic [15:0] l;
        logic [7:0]  s;
        l = l_in;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s[i] = l[15];
            l    = {l[14:5], l[4] ^ l[15], l[3] ^ l[15], l[2] ^ l[15], l[1:0], l[15]};
        end
        return {s, l};
    endfunction

    always_comb begin
        logic [15:0] w_walk;
        logic [23:0] w_step;
        logic [7:0]  w_sym;
        logic        w_is_k;

        w_reload     = scrambler_reset;
        w_lfsr_start = scrambler_reset ? SEED : r_lfsr;
`ifdef SCR_SEED_LOAD_EN
        w_reload = scrambler_reset | seed_load;
        if (seed_load) begin
            w_lfsr_start = seed_value;
        end
`endif
        w_walk     = w_lfsr_start;
        w_out_data = bus.in_data;
        w_step     = '0;
        w_sym      = '0;
        w_is_k     = 1'b0;

        // Each byte sees the LFSR left behind by the byte before it, so COM mid-beat reseeds the rest.
        for (int b = 0; b < NUM_BYTES; b++) begin
            w_sym  = bus.in_data[8*b +: 8];
            w_is_k = bus.in_k[b];
            w_step = scr_advance8(w_walk);
            if (w_is_k && (w_sym == K_COM)) begin
                w_walk = SEED;
            end else if (!(w_is_k && (w_sym == K_SKP))) begin
                w_walk = w_step[15:0];
                if (!w_is_k && !scrambler_disable) begin
                    w_out_data[8*b +: 8] = w_sym ^ w_step[23:16];
                end
            end
        end
        w_lfsr_next = w_walk;
    end

    always_ff @(posedge clk_i or negedge system_reset) begin
        if (!system_reset) begin
            r_lfsr      <= SEED;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_k     <= '0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_lfsr     <= w_lfsr_next;
                r_out_data <= w_out_data;
                r_out_k    <= bus.in_k;
            end else if (w_reload) begin
                r_lfsr <= w_lfsr_start;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_k     = r_out_k;

`ifdef SCR_SEED_LOAD_EN
    assign lfsr_state_o = r_lfsr;
`endif

endmodule

// File: tb/tb_pcie_scrambler_par.sv
// Bench for pcie_scrambler_par: directed checks on 1-byte and 4-byte lanes plus randomized beats
// compared against a polynomial-arithmetic reference model.
module tb_pcie_scrambler_par;

    localparam logic [15:0] SEED = 16'hFFFF;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic system_reset;
    logic sr1, dis1, sr4, dis4;
    int   n_vec = 0;
    int   n_err = 0;
    logic [36:0] exp_q[$];

    pcie_scrambler_par_if #(.NUM_BYTES(1)) if1();
    pcie_scrambler_par_if #(.NUM_BYTES(4)) if4();

`ifdef SCR_SEED_LOAD_EN
    logic [15:0] lfsr1, lfsr4;
`endif

    pcie_scrambler_par #(.NUM_BYTES(1), .SEED(SEED)) u_dut1 (
        .clk_i(clk_i),
        .system_reset(system_reset),
        .scrambler_reset(sr1),
        .scrambler_disable(dis1),
`ifdef SCR_SEED_LOAD_EN
        .seed_load(1'b0),
        .seed_value(16'h0000),
        .lfsr_state_o(lfsr1),
`endif
        .bus(if1)
    );

    pcie_scrambler_par #(.NUM_BYTES(4), .SEED(SEED)) u_dut4 (
        .clk_i(clk_i),
        .system_reset(system_reset),
        .scrambler_reset(sr4),
        .scrambler_disable(dis4),
`ifdef SCR_SEED_LOAD_EN
        .seed_load(1'b0),
        .seed_value(16'h0000),
        .lfsr_state_o(lfsr4),
`endif
        .bus(if4)
    );

    // Reference: one symbol through the scrambler rules, LFSR kept as a plain 16-bit polynomial value.
    task automatic mdl_symbol(input logic [7:0] d, input logic k, input logic dis,
                              input logic [15:0] lin, output logic [7:0] o, output logic [15:0] lout);
        logic [15:0] l;
        logic [7:0]  s;
        logic        msb;
        l = lin;
        s = '0;
        o = d;
        if (k && d == 8'hBC) begin
            lout = SEED;
        end else if (k && d == 8'h1C) begin
            lout = lin;
        end else begin
            for (int i = 0; i < 8; i++) begin
                msb  = l[15];
                s[i] = msb;
                l    = (l << 1) ^ (msb ? 16'h0039 : 16'h0000);
            end
            lout = l;
            if (!k && !dis) o = d ^ s;
        end
    endtask

    task automatic drive1(input logic v, input logic [7:0] d, input logic k, input logic dis, input logic sr);
        @(negedge clk_i);
        if1.in_valid = v; if1.in_data = d; if1.in_k = k; dis1 = dis; sr1 = sr;
        if4.in_valid = 1'b0; sr4 = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic drive4(input logic v, input logic [31:0] d, input logic [3:0] k, input logic dis, input logic sr);
        @(negedge clk_i);
        if4.in_valid = v; if4.in_data = d; if4.in_k = k; dis4 = dis; sr4 = sr;
        if1.in_valid = 1'b0; sr1 = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset;
        @(negedge clk_i);
        system_reset = 1'b0;
        if1.in_valid = 1'b0; if4.in_valid = 1'b0; sr1 = 1'b0; sr4 = 1'b0;
        repeat (2) @(negedge clk_i);
        system_reset = 1'b1;
    endtask

    task automatic test_reset;
        #12;
        n_vec++;
        if ({if1.out_valid, if1.out_k, if1.out_data} !== 10'h0) begin
            n_err++;
            $display("FAIL reset_dut1: got %h want 000", {if1.out_valid, if1.out_k, if1.out_data});
        end
        n_vec++;
        if ({if4.out_valid, if4.out_k, if4.out_data} !== 37'h0) begin
            n_err++;
            $display("FAIL reset_dut4: got %h want 0", {if4.out_valid, if4.out_k, if4.out_data});
        end
        @(negedge clk_i);
        system_reset = 1'b1;
    endtask

    task automatic test_com_data;
        logic [7:0] din[4];
        logic [7:0] dout[4];
        din  = '{8'hBC, 8'h00, 8'h00, 8'h00};
        dout = '{8'hBC, 8'hFF, 8'h17, 8'hC0};
        for (int i = 0; i < 4; i++) begin
            drive1(1'b1, din[i], (i == 0), 1'b0, 1'b0);
            n_vec++;
            if ({if1.out_valid, if1.out_k, if1.out_data} !== {1'b1, (i == 0), dout[i]}) begin
                n_err++;
                $display("FAIL com_data[%0d]: got %h want %h", i,
                         {if1.out_valid, if1.out_k, if1.out_data}, {1'b1, (i == 0), dout[i]});
            end
        end
    endtask

    task automatic test_skp;
        logic [7:0] din[5];
        logic [7:0] dout[5];
        logic       kin[5];
        din  = '{8'hBC, 8'h1C, 8'h1C, 8'h00, 8'h00};
        kin  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        dout = '{8'hBC, 8'h1C, 8'h1C, 8'hFF, 8'h17};
        for (int i = 0; i < 5; i++) begin
            drive1(1'b1, din[i], kin[i], 1'b0, 1'b0);
            n_vec++;
            if ({if1.out_valid, if1.out_k, if1.out_data} !== {1'b1, kin[i], dout[i]}) begin
                n_err++;
                $display("FAIL skp[%0d]: got %h want %h", i,
                         {if1.out_valid, if1.out_k, if1.out_data}, {1'b1, kin[i], dout[i]});
            end
        end
    endtask

    task automatic test_multi_byte;
        logic [31:0] din[4];
        logic [3:0]  kin[4];
        logic [31:0] dout[4];
        din  = '{32'h000000BC, 32'h00000000, 32'h000000BC, 32'h1CBC1C00};
        kin  = '{4'b0001, 4'b0000, 4'b0010, 4'b1110};
        dout = '{32'hC017FFBC, 32'h02E7B214, 32'h17FFBC82, 32'h1CBC1C00};
        // Third beat: COM in byte 1 reseeds bytes 2-3; fourth: SKP/COM/SKP then data from SEED.
        din[2]  = 32'h0000BC00;
        din[3]  = 32'h001CBC1C;
        kin[3]  = 4'b0111;
        dout[3] = 32'hFF1CBC1C;
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, din[i], kin[i], 1'b0, 1'b0);
            n_vec++;
            if ({if4.out_valid, if4.out_k, if4.out_data} !== {1'b1, kin[i], dout[i]}) begin
                n_err++;
                $display("FAIL multi_byte[%0d]: got %h want %h", i,
                         {if4.out_valid, if4.out_k, if4.out_data}, {1'b1, kin[i], dout[i]});
            end
        end
    endtask

    task automatic test_disable;
        drive1(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
        drive1(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({if1.out_valid, if1.out_data} !== 9'h100) begin
            n_err++;
            $display("FAIL disable_pass: got %h want 100", {if1.out_valid, if1.out_data});
        end
        drive1(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({if1.out_valid, if1.out_data} !== 9'h117) begin
            n_err++;
            $display("FAIL disable_advance: got %h want 117", {if1.out_valid, if1.out_data});
        end
    endtask

    task automatic test_gap;
        drive1(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
        drive1(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({if1.out_valid, if1.out_data} !== 9'h1FF) begin
            n_err++;
            $display("FAIL gap_first: got %h want 1ff", {if1.out_valid, if1.out_data});
        end
        for (int i = 0; i < 5; i++) begin
            drive1(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if ({if1.out_valid, if1.out_k, if1.out_data} !== 10'h0FF) begin
                n_err++;
                $display("FAIL gap_idle[%0d]: got %h want 0ff", i, {if1.out_valid, if1.out_k, if1.out_data});
            end
        end
        drive1(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({if1.out_valid, if1.out_data} !== 9'h117) begin
            n_err++;
            $display("FAIL gap_resume: got %h want 117", {if1.out_valid, if1.out_data});
        end
    endtask

    task automatic test_scrambler_reset;
        drive1(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive1(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        drive1(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if ({if1.out_valid, if1.out_data} !== 9'h1FF) begin
            n_err++;
            $display("FAIL sreset_valid: got %h want 1ff", {if1.out_valid, if1.out_data});
        end
        drive1(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({if1.out_valid, if1.out_data} !== 9'h117) begin
            n_err++;
            $display("FAIL sreset_next: got %h want 117", {if1.out_valid, if1.out_data});
        end
        drive1(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive1(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({if1.out_valid, if1.out_data} !== 9'h1FF) begin
            n_err++;
            $display("FAIL sreset_idle: got %h want 1ff", {if1.out_valid, if1.out_data});
        end
    endtask

    task automatic test_async_reset;
        drive1(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
        drive1(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        #2;
        system_reset = 1'b0;
        #1;
        n_vec++;
        if ({if1.out_valid, if1.out_k, if1.out_data} !== 10'h000) begin
            n_err++;
            $display("FAIL async_reset: got %h want 000", {if1.out_valid, if1.out_k, if1.out_data});
        end
        @(negedge clk_i);
        if1.in_valid = 1'b0;
        system_reset = 1'b1;
        drive1(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({if1.out_valid, if1.out_data} !== 9'h1FF) begin
            n_err++;
            $display("FAIL async_resume: got %h want 1ff", {if1.out_valid, if1.out_data});
        end
    endtask

    task automatic test_random(input int nbytes, input int beats);
        logic [7:0]  kv[4];
        logic [15:0] m, lf;
        logic [31:0] d, od, last_d;
        logic [3:0]  k, last_k;
        logic [7:0]  o;
        logic        v, sr, dis;
        logic [36:0] got, exp_v;
        kv = '{8'hBC, 8'h1C, 8'hF7, 8'hFC};
        do_reset;
        m = SEED; last_d = '0; last_k = '0;
        exp_q.delete();
        for (int n = 0; n < beats; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            sr  = ($urandom_range(0, 15) == 0);
            dis = ($urandom_range(0, 7) == 0);
            d = '0; k = '0;
            for (int b = 0; b < nbytes; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    k[b] = 1'b1;
                    d[8*b +: 8] = kv[$urandom_range(0, 3)];
                end else begin
                    d[8*b +: 8] = 8'($urandom_range(0, 255));
                end
            end
            lf = sr ? SEED : m;
            od = '0;
            for (int b = 0; b < nbytes; b++) begin
                mdl_symbol(d[8*b +: 8], k[b], dis, lf, o, lf);
                od[8*b +: 8] = o;
            end
            if (v) begin
                m = lf; last_d = od; last_k = k;
            end else if (sr) begin
                m = SEED;
            end
            exp_q.push_back({v, last_k, last_d});
            if (nbytes == 4) begin
                drive4(v, d, k, dis, sr);
                got = {if4.out_valid, if4.out_k, if4.out_data};
            end else begin
                drive1(v, d[7:0], k[0], dis, sr);
                got = {if1.out_valid, 3'b000, if1.out_k, 24'h0, if1.out_data};
            end
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL random%0d[%0d]: got %h want %h", nbytes, n, got, exp_v);
            end
        end
    endtask

    initial begin
        system_reset = 1'b0;
        sr1 = 1'b0; dis1 = 1'b0; sr4 = 1'b0; dis4 = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.in_k = '0;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.in_k = '0;
        test_reset;
        test_com_data;
        test_skp;
        test_multi_byte;
        test_disable;
        test_gap;
        test_scrambler_reset;
        test_async_reset;
        test_random(1, 300);
        test_random(4, 400);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
